// File: rtl/board_io_conditioner.sv
// Board pin conditioner: synchronises and deglitches the SPI-side input pins,
// shapes the core interrupt into a PIRQ_n pulse and stretches an activity LED.
module board_io_conditioner #(
   parameter int              N_IN        = 4,
   parameter int              SYNC_STAGES = 2,
   parameter int              FILT_LEN    = 3,
   parameter logic [N_IN-1:0] RST_VAL     = {N_IN{1'b1}},
   parameter int              IRQ_MIN_CYC = 16,
   parameter int              IRQ_GAP     = 8,
   parameter int              ACT_CH      = 2,
   parameter int              ACT_W       = 22
) (
   input  logic            CLOCK_100,
   input  logic            RESET,
   input  logic [N_IN-1:0] pin_in,
   output logic [N_IN-1:0] pin_sync,
   output logic [N_IN-1:0] pin_rise,
   output logic [N_IN-1:0] pin_fall,
   input  logic            irq_req,
   output logic            irq_n_out,
   output logic            act_led
);

   localparam logic [3:0] FILT_LAST   = 4'(FILT_LEN - 1);
   localparam int         IRQ_CNT_MAX = (IRQ_MIN_CYC > IRQ_GAP) ? IRQ_MIN_CYC : IRQ_GAP;
   localparam int         IRQ_CW      = (IRQ_CNT_MAX > 1) ? $clog2(IRQ_CNT_MAX) : 1;
   localparam logic [IRQ_CW-1:0] MIN_LOAD = IRQ_CW'(IRQ_MIN_CYC - 1);
   localparam logic [IRQ_CW-1:0] GAP_LOAD = (IRQ_GAP > 0) ? IRQ_CW'(IRQ_GAP - 1) : '0;

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} irq_state_t;

   logic [N_IN-1:0] sync_q [SYNC_STAGES];
   logic [N_IN-1:0] sync_out;
   logic [3:0]      filt_cnt [N_IN];

   irq_state_t        state_q, state_d;
   logic [IRQ_CW-1:0] irq_cnt_q, irq_cnt_d;
   logic              req_q;

   logic [ACT_W-1:0]  led_cnt_q, led_cnt_d;

   // NOTE: every clocked process uses <= so all registers update from
   // pre-edge values, which makes the stage-to-stage shift order-independent.
   always_ff @(posedge CLOCK_100) begin
      if (RESET) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
      end else begin
         sync_q[0] <= pin_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Strobes are set in the same edge that updates pin_sync, so they line up
   // with the first cycle the new level is visible.
   always_ff @(posedge CLOCK_100) begin
      if (RESET) begin
         pin_sync <= RST_VAL;
         pin_rise <= '0;
         pin_fall <= '0;
         for (int i = 0; i < N_IN; i++) filt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            pin_rise[i] <= 1'b0;
            pin_fall[i] <= 1'b0;
            if (sync_out[i] == pin_sync[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FILT_LAST) begin
               pin_sync[i] <= sync_out[i];
               pin_rise[i] <= sync_out[i];
               pin_fall[i] <= ~sync_out[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + 4'd1;
            end
         end
      end
   end

   // NOTE: next-state values are defaulted to the current ones first so no
   // path through the case leaves them unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      irq_cnt_d = irq_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (irq_req) begin
               state_d   = ACTIVE;
               irq_cnt_d = MIN_LOAD;
            end
         end
         ACTIVE: begin
            // Release only after the request has been low for two samples,
            // so the pulse outlasts a long request by one cycle.
            if (irq_cnt_q != '0) begin
               irq_cnt_d = irq_cnt_q - IRQ_CW'(1);
            end else if (!irq_req && !req_q) begin
               if (IRQ_GAP == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d   = GAP;
                  irq_cnt_d = GAP_LOAD;
               end
            end
         end
         GAP: begin
            if (irq_cnt_q != '0) irq_cnt_d = irq_cnt_q - IRQ_CW'(1);
            else                 state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_100) begin
      if (RESET) begin
         state_q   <= IDLE;
         irq_cnt_q <= '0;
         req_q     <= 1'b0;
         irq_n_out <= 1'b1;
      end else begin
         state_q   <= state_d;
         irq_cnt_q <= irq_cnt_d;
         req_q     <= irq_req;
         irq_n_out <= (state_q != ACTIVE);
      end
   end

   always_comb begin
      led_cnt_d = led_cnt_q;
      if (pin_fall[ACT_CH])       led_cnt_d = '1;
      else if (led_cnt_q != '0)   led_cnt_d = led_cnt_q - ACT_W'(1);
   end

   always_ff @(posedge CLOCK_100) begin
      if (RESET) begin
         led_cnt_q <= '0;
         act_led   <= 1'b0;
      end else begin
         led_cnt_q <= led_cnt_d;
         act_led   <= (led_cnt_d != '0);
      end
   end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Self-checking bench for board_io_conditioner: a timeline/window reference
// model checked every cycle, directed literal checks, then random stimulus.
module tb_board_io_conditioner;

   localparam int              N_IN     = 4;
   localparam int              SYNC     = 2;
   localparam int              FILT     = 3;
   localparam logic [N_IN-1:0] RST_VAL  = 4'b1111;
   localparam int              IRQ_MIN  = 16;
   localparam int              IRQ_GAP  = 8;
   localparam int              ACT_CH   = 2;
   localparam int              ACT_W    = 4;
   localparam int              LED_HOLD = (1 << ACT_W) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_IN-1:0] pin_in = '0;
   logic            irq_req = 1'b0;
   logic [N_IN-1:0] pin_sync, pin_rise, pin_fall;
   logic            irq_n_out, act_led;

   board_io_conditioner #(
      .N_IN(N_IN), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .RST_VAL(RST_VAL),
      .IRQ_MIN_CYC(IRQ_MIN), .IRQ_GAP(IRQ_GAP), .ACT_CH(ACT_CH), .ACT_W(ACT_W)
   ) dut (
      .CLOCK_100(clk), .RESET(rst), .pin_in(pin_in), .pin_sync(pin_sync),
      .pin_rise(pin_rise), .pin_fall(pin_fall), .irq_req(irq_req),
      .irq_n_out(irq_n_out), .act_led(act_led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state, indexed by edge number k.
   int              k = 0;
   int              last_rst = 0;
   logic [N_IN-1:0] samp[$];
   logic [N_IN-1:0] m_ps, m_rise, m_fall;
   int              last_act_fall = -100000;
   logic            m_led, m_irq_n;
   bit              m_active, req_prev;
   int              act_start, idle_from;

   // Observed DUT outputs per step, for the directed literal checks.
   int              step_no = 0;
   logic [N_IN-1:0] hist_sync[$], hist_rise[$], hist_fall[$];
   logic            hist_irq[$], hist_led[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
      end
   endtask

   // Level seen by the filter at edge e: synchroniser chain holds RST_VAL
   // for SYNC edges after a reset, otherwise it delays the pin by SYNC edges.
   function automatic logic [N_IN-1:0] d_at(input int e);
      if (e - last_rst <= SYNC) return RST_VAL;
      return samp[e - SYNC];
   endfunction

   task automatic model_edge(input logic r, input logic [N_IN-1:0] p, input logic q);
      logic [N_IN-1:0] new_ps, dv;
      bit flip;
      samp.push_back(p);
      if (r) begin
         last_rst      = k;
         m_ps          = RST_VAL;
         m_rise        = '0;
         m_fall        = '0;
         m_led         = 1'b0;
         last_act_fall = -100000;
         m_active      = 1'b0;
         idle_from     = k;
         req_prev      = 1'b0;
         m_irq_n       = 1'b1;
      end else begin
         // A level changes once FILT consecutive filter samples disagree.
         new_ps = m_ps;
         for (int i = 0; i < N_IN; i++) begin
            flip = (k - FILT + 1 > last_rst);
            for (int w = 0; w < FILT; w++) begin
               dv = d_at(k - w);
               if (dv[i] == m_ps[i]) flip = 1'b0;
            end
            if (flip) new_ps[i] = ~m_ps[i];
         end
         m_rise = new_ps & ~m_ps;
         m_fall = ~new_ps & m_ps;
         m_ps   = new_ps;

         m_led = (k - last_act_fall >= 1) && (k - last_act_fall <= LED_HOLD);
         if (m_fall[ACT_CH]) last_act_fall = k;

         m_irq_n = !m_active;
         if (m_active) begin
            if ((k - act_start >= IRQ_MIN) && !q && !req_prev) begin
               m_active  = 1'b0;
               idle_from = k + IRQ_GAP;
            end
         end else if ((k - 1 >= idle_from) && q) begin
            m_active  = 1'b1;
            act_start = k;
         end
         req_prev = q;
      end
      k++;
   endtask

   task automatic step(input logic r, input logic [N_IN-1:0] p, input logic q);
      rst     = r;
      pin_in  = p;
      irq_req = q;
      @(posedge clk);
      model_edge(r, p, q);
      @(negedge clk);
      check("pin_sync",  32'(pin_sync),  32'(m_ps));
      check("pin_rise",  32'(pin_rise),  32'(m_rise));
      check("pin_fall",  32'(pin_fall),  32'(m_fall));
      check("irq_n_out", 32'(irq_n_out), 32'(m_irq_n));
      check("act_led",   32'(act_led),   32'(m_led));
      hist_sync.push_back(pin_sync);
      hist_rise.push_back(pin_rise);
      hist_fall.push_back(pin_fall);
      hist_irq.push_back(irq_n_out);
      hist_led.push_back(act_led);
      step_no++;
   endtask

   function automatic int find_fall(input int from, input int ch);
      for (int i = from; i < hist_fall.size(); i++) if (hist_fall[i][ch] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int find_rise(input int from, input int ch);
      for (int i = from; i < hist_rise.size(); i++) if (hist_rise[i][ch] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int quiet_violations(input int from, input int to, input int ch);
      int n = 0;
      for (int i = from; i < to; i++)
         if (hist_rise[i][ch] !== 1'b0 || hist_fall[i][ch] !== 1'b0 || hist_sync[i][ch] !== 1'b1) n++;
      return n;
   endfunction

   function automatic int find_irq(input int from, input logic lvl);
      for (int i = from; i < hist_irq.size(); i++) if (hist_irq[i] === lvl) return i;
      return -1;
   endfunction

   function automatic int run_irq(input int from, input logic lvl);
      int n = 0;
      for (int i = from; i < hist_irq.size() && hist_irq[i] === lvl; i++) n++;
      return n;
   endfunction

   function automatic int find_led(input int from);
      for (int i = from; i < hist_led.size(); i++) if (hist_led[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int run_led(input int from);
      int n = 0;
      for (int i = from; i < hist_led.size() && hist_led[i] === 1'b1; i++) n++;
      return n;
   endfunction

   initial begin
      int j, f, h, s2, req_left, rst_left, b;
      logic [N_IN-1:0] cur, p;
      logic q, r;

      // Reset with all pins low: held at RST_VAL, no strobes.
      repeat (3) step(1'b1, 4'b0000, 1'b0);
      check("rst_sync",    32'(hist_sync[2]), 32'hF);
      check("rst_strobes", 32'(hist_rise[2] | hist_fall[2]), 32'h0);
      check("rst_irq_n",   32'(hist_irq[2]), 32'h1);
      check("rst_led",     32'(hist_led[2]), 32'h0);
      repeat (6) step(1'b0, 4'b0000, 1'b0);
      // j is the last step before the change; latencies count from it.
      check("rel_sync_c4", 32'(hist_sync[6]), 32'hF);
      check("rel_sync_c5", 32'(hist_sync[7]), 32'h0);
      check("rel_fall_c5", 32'(hist_fall[7]), 32'hF);
      check("rel_fall_c6", 32'(hist_fall[8]), 32'h0);
      repeat (30) step(1'b0, 4'hF, 1'b0);

      // Glitch rejection on channel 1.
      j = step_no - 1;
      repeat (2) step(1'b0, 4'b1101, 1'b0);
      repeat (12) step(1'b0, 4'hF, 1'b0);
      check("glitch2_quiet", quiet_violations(j + 1, step_no, 1), 0);
      j = step_no - 1;
      repeat (3) step(1'b0, 4'b1101, 1'b0);
      repeat (12) step(1'b0, 4'hF, 1'b0);
      f = find_fall(j + 1, 1);
      check("glitch3_fall_lat", f - j, 5);
      check("glitch3_rise_gap", find_rise(f, 1) - f, 3);

      // IRQ minimum width and long request.
      j = step_no - 1;
      step(1'b0, 4'hF, 1'b1);
      repeat (40) step(1'b0, 4'hF, 1'b0);
      f = find_irq(j + 1, 1'b0);
      check("irq1_lat",   f - j, 2);
      check("irq1_width", run_irq(f, 1'b0), 16);
      j = step_no - 1;
      repeat (40) step(1'b0, 4'hF, 1'b1);
      repeat (60) step(1'b0, 4'hF, 1'b0);
      f = find_irq(j + 1, 1'b0);
      check("irq40_lat",   f - j, 2);
      check("irq40_width", run_irq(f, 1'b0), 41);

      // Request re-raised two cycles into the gap.
      j = step_no - 1;
      step(1'b0, 4'hF, 1'b1);
      repeat (18) step(1'b0, 4'hF, 1'b0);
      repeat (14) step(1'b0, 4'hF, 1'b1);
      repeat (50) step(1'b0, 4'hF, 1'b0);
      f  = find_irq(j + 1, 1'b0);
      h  = f + run_irq(f, 1'b0);
      s2 = find_irq(h, 1'b0);
      check("irq_gap", s2 - h, 9);

      // Reset aborts a pulse.
      step(1'b0, 4'hF, 1'b1);
      repeat (6) step(1'b0, 4'hF, 1'b0);
      step(1'b1, 4'hF, 1'b0);
      check("irq_low_before_rst", 32'(hist_irq[step_no - 2]), 32'h0);
      check("irq_rst_abort",      32'(hist_irq[step_no - 1]), 32'h1);
      repeat (5) step(1'b0, 4'hF, 1'b0);

      // Activity LED: single strobe, retrigger, reset mid-stretch.
      j = step_no - 1;
      repeat (20) step(1'b0, 4'b1011, 1'b0);
      f = find_led(j + 1);
      check("led_fall_lat", find_fall(j + 1, ACT_CH) - j, 5);
      check("led_lat",      f - find_fall(j + 1, ACT_CH), 1);
      check("led_width",    run_led(f), 15);
      repeat (5) step(1'b0, 4'hF, 1'b0);
      j = step_no - 1;
      repeat (3) step(1'b0, 4'b1011, 1'b0);
      repeat (7) step(1'b0, 4'hF, 1'b0);
      repeat (30) step(1'b0, 4'b1011, 1'b0);
      f = find_led(j + 1);
      check("led_retrig_width", run_led(f), 25);
      repeat (6) step(1'b0, 4'hF, 1'b0);
      repeat (8) step(1'b0, 4'b1011, 1'b0);
      step(1'b1, 4'b1011, 1'b0);
      check("led_before_rst", 32'(hist_led[step_no - 2]), 32'h1);
      check("led_rst_abort",  32'(hist_led[step_no - 1]), 32'h0);

      // Random phase: slow pin toggles, isolated glitches, variable requests.
      cur      = 4'b1011;
      req_left = 0;
      rst_left = 0;
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < N_IN; i++)
            if ($urandom_range(0, 7) == 0) cur[i] = ~cur[i];
         p = cur;
         if ($urandom_range(0, 15) == 0) begin
            b = $urandom_range(0, N_IN - 1);
            p[b] = ~p[b];
         end
         q = 1'b0;
         if (req_left > 0) begin
            q = 1'b1;
            req_left--;
         end else if ($urandom_range(0, 19) == 0) begin
            req_left = $urandom_range(1, 30);
         end
         r = 1'b0;
         if (rst_left > 0) begin
            r = 1'b1;
            rst_left--;
         end else if ($urandom_range(0, 399) == 0) begin
            r = 1'b1;
            rst_left = $urandom_range(0, 2);
         end
         step(r, p, q);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
